// File: rtl/ddr_data_burst.sv
// DDR data-path burst engine: queues sequencer requests, serialises writes onto DQ/DQS and assembles read bursts.
// Optional burst-chop support is enabled with `define DDR_BURST_CHOP_EN.
module ddr_data_burst #(
    parameter int unsigned DQ_WIDTH = 8,
    parameter int unsigned BL       = 8,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic                     clock_t,
    input  logic                     reset,
    input  logic                     rw_rdy,
    input  logic                     rw_dir,
    input  logic                     bc4,
    input  logic [DQ_WIDTH*BL-1:0]   wr_data,
    output logic [2*DQ_WIDTH-1:0]    dq_out,
    output logic                     dq_oe,
    output logic                     dqs_t,
    output logic                     dqs_c,
    input  logic [2*DQ_WIDTH-1:0]    dq_in,
    output logic [DQ_WIDTH*BL-1:0]   rd_data,
    output logic                     rd_valid,
    output logic                     busy,
    output logic                     overflow
);
    localparam int unsigned BW = DQ_WIDTH * BL;
    localparam int unsigned AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = $clog2(BL + 1);
`ifdef DDR_BURST_CHOP_EN
    localparam int unsigned EW = BW + 2;
`else
    localparam int unsigned EW = BW + 1;
`endif

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] PREAMBLE  = 2'd1;
    localparam logic [1:0] BURST     = 2'd2;
    localparam logic [1:0] POSTAMBLE = 2'd3;

    logic [EW-1:0] q_mem [QDEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_n;
    logic [EW-1:0] in_entry, head;
    logic          q_empty, q_full, pop, take_in, push_req, accept, drop;

    logic [1:0]    state, state_n;
    logic [EW-1:0] act, act_n;
    logic [CW-1:0] cnt, cnt_n, last_cnt;
    logic          act_dir, act_chop, n_dir, rd_fire;
    logic [BW-1:0] n_data, asm_buf, asm_n, rd_next;
    logic          oe_n, dqs_n;
    logic [2*DQ_WIDTH-1:0] out_n;

`ifdef DDR_BURST_CHOP_EN
    assign in_entry = {rw_dir, bc4, wr_data};
    assign act_chop = act[BW];
`else
    logic unused_bc4;
    assign unused_bc4 = bc4;
    assign in_entry   = {rw_dir, wr_data};
    assign act_chop   = 1'b0;
`endif

    assign act_dir  = act[EW-1];
    assign head     = q_mem[rd_ptr];
    assign q_empty  = (count == '0);
    assign q_full   = (count == (AW+1)'(QDEPTH));
    assign last_cnt = act_chop ? CW'(2) : CW'(BL - 2);
    assign busy     = (state != IDLE) || !q_empty;

    // Next-state: an idle engine with an empty queue takes a new request directly
    always_comb begin
        state_n = state;
        act_n   = act;
        cnt_n   = cnt;
        pop     = 1'b0;
        take_in = 1'b0;
        rd_fire = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!q_empty) begin
                    pop     = 1'b1;
                    act_n   = head;
                    state_n = PREAMBLE;
                end else if (rw_rdy) begin
                    take_in = 1'b1;
                    act_n   = in_entry;
                    state_n = PREAMBLE;
                end
            end
            PREAMBLE: begin
                cnt_n   = '0;
                state_n = BURST;
            end
            BURST: begin
                cnt_n = cnt + CW'(2);
                if (cnt == last_cnt) begin
                    rd_fire = !act_dir;
                    cnt_n   = '0;
                    if (!q_empty && (head[EW-1] == act_dir)) begin
                        pop   = 1'b1;
                        act_n = head;
                    end else begin
                        state_n = POSTAMBLE;
                    end
                end
            end
            default: begin
                cnt_n = '0;
                if (!q_empty) begin
                    pop     = 1'b1;
                    act_n   = head;
                    state_n = PREAMBLE;
                end else begin
                    state_n = IDLE;
                end
            end
        endcase
    end

    assign push_req = rw_rdy && !take_in;
    assign accept   = push_req && (!q_full || pop);
    assign drop     = push_req && q_full && !pop;

    always_comb begin
        case ({accept, pop})
            2'b10:   count_n = count + (AW+1)'(1);
            2'b01:   count_n = count - (AW+1)'(1);
            default: count_n = count;
        endcase
    end

    // Pin values for the coming cycle, registered so they line up with the state
    always_comb begin
        n_dir  = act_n[EW-1];
        n_data = act_n[BW-1:0];
        oe_n   = 1'b0;
        dqs_n  = 1'b0;
        out_n  = '0;
        case (state_n)
            PREAMBLE:  oe_n = n_dir;
            BURST: begin
                oe_n  = n_dir;
                dqs_n = 1'b1;
                if (n_dir) out_n = n_data[int'(cnt_n)*DQ_WIDTH +: 2*DQ_WIDTH];
            end
            POSTAMBLE: oe_n = dq_oe;
            default:   oe_n = 1'b0;
        endcase
    end

    always_comb begin
        asm_n = asm_buf;
        if (state == BURST && !act_dir) asm_n[int'(cnt)*DQ_WIDTH +: 2*DQ_WIDTH] = dq_in;
        rd_next = asm_n;
`ifdef DDR_BURST_CHOP_EN
        if (act_chop) begin
            for (int k = 4; k < int'(BL); k++) rd_next[k*DQ_WIDTH +: DQ_WIDTH] = '0;
        end
`endif
    end

    always_ff @(posedge clock_t) begin
        if (accept) q_mem[wr_ptr] <= in_entry;
    end

    always_ff @(posedge clock_t or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            act      <= '0;
            cnt      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            asm_buf  <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            dq_oe    <= 1'b0;
            dq_out   <= '0;
            dqs_t    <= 1'b0;
            dqs_c    <= 1'b1;
        end else begin
            state    <= state_n;
            act      <= act_n;
            cnt      <= cnt_n;
            count    <= count_n;
            if (accept) wr_ptr <= (wr_ptr == AW'(QDEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            if (pop)    rd_ptr <= (rd_ptr == AW'(QDEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            overflow <= overflow | drop;
            asm_buf  <= asm_n;
            if (rd_fire) rd_data <= rd_next;
            rd_valid <= rd_fire;
            dq_oe    <= oe_n;
            dq_out   <= out_n;
            dqs_t    <= dqs_n;
            dqs_c    <= ~dqs_n;
        end
    end
endmodule

// File: tb/tb_ddr_data_burst.sv
// Bench for ddr_data_burst: per-cycle vector table for pin timing plus a read-data scoreboard.
module tb_ddr_data_burst;
    localparam int unsigned DQ_WIDTH = 8;
    localparam int unsigned BL       = 8;
    localparam int unsigned QDEPTH   = 4;
    localparam int unsigned BW       = DQ_WIDTH * BL;
    localparam int unsigned NROWS    = 34;
`ifdef DDR_BURST_CHOP_EN
    localparam bit CHOP = 1'b1;
`else
    localparam bit CHOP = 1'b0;
`endif
    localparam logic [BW-1:0] D0 = 64'h0706050403020100;
    localparam logic [BW-1:0] D1 = 64'h8786858483828180;

    logic clock_t = 1'b0;
    logic reset   = 1'b1;
    logic rw_rdy  = 1'b0;
    logic rw_dir  = 1'b0;
    logic bc4     = 1'b0;
    logic [BW-1:0] wr_data = '0;
    logic [15:0]   dq_out, dq_in;
    logic          dq_oe, dqs_t, dqs_c, rd_valid, busy, overflow;
    logic [BW-1:0] rd_data;

    int total = 0;
    int bad   = 0;
    int burst_cycles = 0;
    int rdv_count    = 0;
    logic [BW-1:0] exp_q [$];
    logic [7:0] rb     = 8'h10;
    logic [7:0] exp_rb = 8'h10;

    typedef struct {
        logic          rdy;
        logic          dir;
        logic [BW-1:0] data;
        logic          oe;
        logic          dqs;
        logic [15:0]   out;
        logic          bsy;
    } vec_t;
    vec_t tbl [NROWS];

    ddr_data_burst #(.DQ_WIDTH(DQ_WIDTH), .BL(BL), .QDEPTH(QDEPTH)) dut (
        .clock_t (clock_t),
        .reset   (reset),
        .rw_rdy  (rw_rdy),
        .rw_dir  (rw_dir),
        .bc4     (bc4),
        .wr_data (wr_data),
        .dq_out  (dq_out),
        .dq_oe   (dq_oe),
        .dqs_t   (dqs_t),
        .dqs_c   (dqs_c),
        .dq_in   (dq_in),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .busy    (busy),
        .overflow(overflow)
    );

    always #5 clock_t = ~clock_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [BW-1:0] next_read(input logic chop);
        logic [BW-1:0] v = '0;
        int n = chop ? 4 : int'(BL);
        for (int k = 0; k < n; k++) v[k*8 +: 8] = exp_rb + 8'(k);
        exp_rb = exp_rb + 8'(n);
        return v;
    endfunction

    task automatic set_row(input int i, input logic rdy, input logic dir, input logic [BW-1:0] data,
                           input logic oe, input logic dqs, input logic [15:0] out, input logic bsy);
        tbl[i].rdy = rdy; tbl[i].dir = dir; tbl[i].data = data;
        tbl[i].oe = oe; tbl[i].dqs = dqs; tbl[i].out = out; tbl[i].bsy = bsy;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        @(negedge clock_t);
        while (busy && n < limit) begin
            @(negedge clock_t);
            n++;
        end
        check("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic wait_dqs(input int limit);
        int n = 0;
        @(negedge clock_t);
        while (!dqs_t && n < limit) begin
            @(negedge clock_t);
            n++;
        end
        check("dqs_timeout", 64'(dqs_t), 64'd1);
    endtask

    task automatic reset_now(input string tag);
        @(posedge clock_t);
        #2 reset = 1'b1;
        #1;
        check({tag, "_dq_oe"},   64'(dq_oe),    64'd0);
        check({tag, "_dq_out"},  64'(dq_out),   64'd0);
        check({tag, "_dqs_t"},   64'(dqs_t),    64'd0);
        check({tag, "_dqs_c"},   64'(dqs_c),    64'd1);
        check({tag, "_busy"},    64'(busy),     64'd0);
        check({tag, "_overflow"},64'(overflow), 64'd0);
        check({tag, "_rd_data"}, rd_data,       64'd0);
        @(posedge clock_t);
        #1 reset = 1'b0;
    endtask

    // Memory model: supplies consecutive bytes on DQ whenever a read burst is on the strobe
    initial begin
        dq_in = 16'hEEEE;
        forever begin
            @(posedge clock_t);
            #1;
            if (dqs_t && !dq_oe) begin
                dq_in = {rb + 8'd1, rb};
                rb    = rb + 8'd2;
            end else begin
                dq_in = 16'hEEEE;
            end
        end
    end

    always @(negedge clock_t) begin
        if (dqs_t) burst_cycles++;
        if (rd_valid) begin
            rdv_count++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_valid: pulse with no read outstanding, rd_data %0h", rd_data);
            end else begin
                check("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdv_before;
        // single write; write then read (2-cycle turnaround); two writes 2 cycles apart (seamless)
        set_row( 0, 1, 1, D0, 0, 0, 16'h0000, 0);
        set_row( 1, 0, 0, '0, 1, 0, 16'h0000, 1);
        set_row( 2, 0, 0, '0, 1, 1, 16'h0100, 1);
        set_row( 3, 0, 0, '0, 1, 1, 16'h0302, 1);
        set_row( 4, 0, 0, '0, 1, 1, 16'h0504, 1);
        set_row( 5, 0, 0, '0, 1, 1, 16'h0706, 1);
        set_row( 6, 0, 0, '0, 1, 0, 16'h0000, 1);
        set_row( 7, 0, 0, '0, 0, 0, 16'h0000, 0);
        set_row( 8, 1, 1, D1, 0, 0, 16'h0000, 0);
        set_row( 9, 1, 0, '0, 1, 0, 16'h0000, 1);
        set_row(10, 0, 0, '0, 1, 1, 16'h8180, 1);
        set_row(11, 0, 0, '0, 1, 1, 16'h8382, 1);
        set_row(12, 0, 0, '0, 1, 1, 16'h8584, 1);
        set_row(13, 0, 0, '0, 1, 1, 16'h8786, 1);
        set_row(14, 0, 0, '0, 1, 0, 16'h0000, 1);
        set_row(15, 0, 0, '0, 0, 0, 16'h0000, 1);
        set_row(16, 0, 0, '0, 0, 1, 16'h0000, 1);
        set_row(17, 0, 0, '0, 0, 1, 16'h0000, 1);
        set_row(18, 0, 0, '0, 0, 1, 16'h0000, 1);
        set_row(19, 0, 0, '0, 0, 1, 16'h0000, 1);
        set_row(20, 0, 0, '0, 0, 0, 16'h0000, 1);
        set_row(21, 0, 0, '0, 0, 0, 16'h0000, 0);
        set_row(22, 1, 1, D0, 0, 0, 16'h0000, 0);
        set_row(23, 0, 0, '0, 1, 0, 16'h0000, 1);
        set_row(24, 1, 1, D1, 1, 1, 16'h0100, 1);
        set_row(25, 0, 0, '0, 1, 1, 16'h0302, 1);
        set_row(26, 0, 0, '0, 1, 1, 16'h0504, 1);
        set_row(27, 0, 0, '0, 1, 1, 16'h0706, 1);
        set_row(28, 0, 0, '0, 1, 1, 16'h8180, 1);
        set_row(29, 0, 0, '0, 1, 1, 16'h8382, 1);
        set_row(30, 0, 0, '0, 1, 1, 16'h8584, 1);
        set_row(31, 0, 0, '0, 1, 1, 16'h8786, 1);
        set_row(32, 0, 0, '0, 1, 0, 16'h0000, 1);
        set_row(33, 0, 0, '0, 0, 0, 16'h0000, 0);

        repeat (2) @(posedge clock_t);
        #1;
        check("rst_dq_oe",    64'(dq_oe),    64'd0);
        check("rst_dq_out",   64'(dq_out),   64'd0);
        check("rst_dqs_t",    64'(dqs_t),    64'd0);
        check("rst_dqs_c",    64'(dqs_c),    64'd1);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_rd_data",  rd_data,       64'd0);
        check("rst_busy",     64'(busy),     64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        @(posedge clock_t);
        #1 reset = 1'b0;

        for (int i = 0; i < int'(NROWS); i++) begin
            @(posedge clock_t);
            #1;
            rw_rdy  = tbl[i].rdy;
            rw_dir  = tbl[i].dir;
            wr_data = tbl[i].data;
            bc4     = 1'b0;
            if (tbl[i].rdy && !tbl[i].dir) exp_q.push_back(next_read(1'b0));
            @(negedge clock_t);
            check($sformatf("row%0d_dq_oe", i),  64'(dq_oe),  64'(tbl[i].oe));
            check($sformatf("row%0d_dqs_t", i),  64'(dqs_t),  64'(tbl[i].dqs));
            check($sformatf("row%0d_dqs_c", i),  64'(dqs_c),  64'(!tbl[i].dqs));
            check($sformatf("row%0d_dq_out", i), 64'(dq_out), 64'(tbl[i].out));
            check($sformatf("row%0d_busy", i),   64'(busy),   64'(tbl[i].bsy));
        end
        @(posedge clock_t);
        #1 rw_rdy = 1'b0;
        wait_idle(50);

        // six back-to-back pushes: write then five reads; the last read finds the queue full
        check("ovf_before", 64'(overflow), 64'd0);
        @(posedge clock_t);
        #1;
        burst_cycles = 0;
        rdv_before   = rdv_count;
        for (int i = 0; i < 6; i++) begin
            rw_rdy  = 1'b1;
            rw_dir  = (i == 0);
            wr_data = D1;
            if (i >= 1 && i <= 4) exp_q.push_back(next_read(1'b0));
            @(posedge clock_t);
            #1;
        end
        rw_rdy = 1'b0;
        wait_idle(200);
        check("ovf_after",        64'(overflow),              64'd1);
        check("ovf_burst_cycles", 64'(burst_cycles),          64'd20);
        check("ovf_rd_valids",    64'(rdv_count - rdv_before), 64'd4);

        // burst-chop request
        @(posedge clock_t);
        #1;
        burst_cycles = 0;
        rw_rdy = 1'b1; rw_dir = 1'b0; bc4 = 1'b1;
        exp_q.push_back(next_read(CHOP));
        @(posedge clock_t);
        #1 rw_rdy = 1'b0; bc4 = 1'b0;
        wait_idle(50);
        check("bc4_burst_cycles", 64'(burst_cycles), CHOP ? 64'd2 : 64'd4);

        // reset mid write burst
        @(posedge clock_t);
        #1 rw_rdy = 1'b1; rw_dir = 1'b1; wr_data = D0;
        @(posedge clock_t);
        #1 rw_rdy = 1'b0;
        wait_dqs(10);
        reset_now("rst_wr");

        // reset mid read burst: the abandoned read must never report
        @(posedge clock_t);
        #1 rw_rdy = 1'b1; rw_dir = 1'b0;
        @(posedge clock_t);
        #1 rw_rdy = 1'b0;
        wait_dqs(10);
        rdv_before = rdv_count;
        reset_now("rst_rd");
        repeat (20) @(posedge clock_t);
        check("rst_no_rd_valid", 64'(rdv_count - rdv_before), 64'd0);
        check("rst_idle_busy",   64'(busy),                   64'd0);
        exp_rb = rb;

        // normal read after reset
        @(posedge clock_t);
        #1 rw_rdy = 1'b1; rw_dir = 1'b0;
        exp_q.push_back(next_read(1'b0));
        @(posedge clock_t);
        #1 rw_rdy = 1'b0;
        wait_idle(50);
        repeat (2) @(negedge clock_t);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ddr_data_burst.md
# ddr_data_burst

Data-path stage directly downstream of the burst read/write sequencer. Each one-cycle `rw_rdy` pulse from the sequencer marks the point at which a burst's data phase must begin. This block queues those burst requests, serialises write bursts onto the DQ/DQS pins, and deserialises read bursts from DQ into a full burst word. Pins are modelled at `clock_t` rate with two beats (rising/falling) per cycle.

## Interface
Parameters:
- `DQ_WIDTH`, 8, bits per beat
- `BL`, 8, burst length in beats; must be even, ≥4
- `QDEPTH`, 4, pending-burst queue depth; power of two

Ports:
- `clock_t` in 1: sole clock, all logic on rising edge
- `reset` in 1: asynchronous, active-high
- `rw_rdy` in 1: one-cycle pulse, push one burst request
- `rw_dir` in 1: 1=write, 0=read; sampled with `rw_rdy`
- `bc4` in 1: burst-chop request; sampled with `rw_rdy` (see Configuration)
- `wr_data` in DQ_WIDTH*BL: write burst, beat k at `[k*DQ_WIDTH +: DQ_WIDTH]`; sampled with `rw_rdy`
- `dq_out` out 2*DQ_WIDTH: low half = rising beat, high half = falling beat
- `dq_oe` out 1: DQ/DQS output enable
- `dqs_t` out 1, `dqs_c` out 1: strobe pair, `dqs_c` = ~`dqs_t` at all times
- `dq_in` in 2*DQ_WIDTH: read beats, same packing as `dq_out`
- `rd_data` out DQ_WIDTH*BL: assembled read burst
- `rd_valid` out 1: one-cycle pulse, `rd_data` valid
- `busy` out 1: state ≠ IDLE or queue non-empty
- `overflow` out 1: sticky, a request was dropped

## Operation
- Queue: FIFO of {dir, bc4, wr_data}, QDEPTH entries.
  - Push on `rw_rdy`.
  - When the queue is full and no pop occurs in the same cycle, the request is dropped and `overflow` is set. Only `reset` clears `overflow`.
  - Simultaneous push and pop when full is legal; no drop.
- FSM states:
  - IDLE: if queue non-empty, pop the head into the active register → PREAMBLE.
  - PREAMBLE: one cycle. `dqs_t`=0. `dq_oe`=1 if write. → BURST.
  - BURST: `beats/2` cycles (`beats` = BL, or 4 if chopped). Beat counter increments by 2 per cycle.
    - Write: drive beats 2i and 2i+1 on `dq_out`.
    - Read: capture `dq_in` into beats 2i and 2i+1.
    - `dqs_t`=1.
    - On the last cycle, if the queue is non-empty and the head has the same dir, pop it and stay in BURST with the counter reset (seamless). Otherwise go to POSTAMBLE.
  - POSTAMBLE: one cycle. `dqs_t`=0. `dq_oe` holds its previous value.
    - Queue non-empty → pop → PREAMBLE.
    - Queue empty → IDLE.
- Reads: `rd_valid` pulses the cycle after the last BURST cycle of each read. `rd_data` holds until the next `rd_valid`. Chopped reads zero beats 4..BL-1.
- Outside write PREAMBLE/BURST/POSTAMBLE: `dq_oe`=0 and `dq_out`=0.

## Timing
- Reset (asynchronous, any state): all outputs 0 except `dqs_c`=1. The state is IDLE, the queue is emptied, and any in-flight burst is abandoned with no `rd_valid`.
- `rw_rdy` at cycle N with IDLE and empty queue:
  - PREAMBLE at N+1.
  - BURST at N+2 .. N+1+BL/2.
  - POSTAMBLE at N+2+BL/2.
  - For a read, `rd_valid` at N+2+BL/2.
- A same-direction request that is present in the queue at the last BURST cycle produces zero gap cycles.
- A direction change costs POSTAMBLE+PREAMBLE (2 cycles) between bursts.
- `busy` is combinational from state and queue count.

## Configuration
- `DDR_BURST_CHOP_EN` defined:
  - `bc4`=1 limits the burst to 4 beats (2 BURST cycles).
  - Write beats 4..BL-1 are never driven.
- Undefined:
  - `bc4` is ignored and every burst is BL beats.
  - The bc4 queue field is omitted.

## Test plan
- Single write, BL=8, `wr_data`=0x0706050403020100, pulse at cycle 10:
  - PREAMBLE at 11.
  - `dq_out` = 0x0100, 0x0302, 0x0504, 0x0706 at 12–15.
  - POSTAMBLE at 16.
  - `dq_oe`=1 for cycles 11–16.
- Single read, `dq_in` driven 0x1110, 0x1312, 0x1514, 0x1716 during BURST → `rd_valid` pulse with `rd_data`=0x1716151413121110.
- Two writes pushed 2 cycles apart → 8 contiguous BURST cycles, no POSTAMBLE between them.
- Write then read → POSTAMBLE, PREAMBLE (`dq_oe`=0), then read BURST. Exactly 2 gap cycles.
- 6 pushes on consecutive cycles with QDEPTH=4 and the engine busy → `overflow`=1 and exactly 5 bursts executed (one in service, four queued).
- `DDR_BURST_CHOP_EN`, read with `bc4`=1 → 2 BURST cycles, upper 32 bits of `rd_data` zero. Also assert `reset` mid-BURST → outputs at reset values immediately, no `rd_valid`.
